// File: rtl/npu_sched_pkg.sv
// Purpose : shared types and constants for the NPU frame scheduler.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package npu_sched_pkg;

  localparam int NPU_ADDR_W    = 12;
  localparam int NPU_DATA_W    = 8;
  localparam int IMG_WORDS_DEF = 3072;  // 32x32x3

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_LOAD,
    S_START,
    S_RUN
  } sched_state_t;

endpackage

// File: rtl/sat_counter.sv
// Purpose : saturating up-counter for scheduler statistics.
// Latency : count visible 1 cycle after inc_i.
// Backpr. : none; holds at all-ones instead of wrapping.
//
// Ports: clk, resetn (async active-low), inc_i (count one event),
//        clear_i (synchronous clear, wins over inc_i), cnt_o (current count).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/npu_frame_scheduler.sv
// Purpose : loads one binned frame into NPU input memory, kicks inference, latches the class.
// Latency : pixel -> mem write 1 cycle; last write -> npu_start 1 cycle; npu_done -> result_valid 1 cycle.
// Backpr. : none on the pixel stream; frames arriving during inference are dropped and counted.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   enable                   level; schedule inferences continuously while high
//   frame_start              1-cycle start-of-frame pulse
//   pix_valid, pix_data      binned pixel strobe and byte
//   mem_we/mem_addr/mem_din  NPU input-memory write port (registered)
//   npu_start                1-cycle inference kick (registered)
//   npu_done, npu_class      inference completion pulse and class index
//   result_valid/_class      1-cycle result pulse and last completed class
//   timeout_err              sticky inference timeout flag
//   drop_cnt, short_cnt      saturating dropped-frame / short-frame counters
//   busy                     high while in START or RUN
module npu_frame_scheduler
  import npu_sched_pkg::*;
#(
  parameter int IMG_WORDS   = IMG_WORDS_DEF,  // must be <= 2**NPU_ADDR_W
  parameter int CLASS_W     = 5,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [NPU_DATA_W-1:0] pix_data,
  output logic                  mem_we,
  output logic [NPU_ADDR_W-1:0] mem_addr,
  output logic [NPU_DATA_W-1:0] mem_din,
  output logic                  npu_start,
  input  logic                  npu_done,
  input  logic [CLASS_W-1:0]    npu_class,
  output logic                  result_valid,
  output logic [CLASS_W-1:0]    result_class,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      short_cnt,
  output logic                  busy
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [NPU_ADDR_W-1:0] LAST_ADDR = NPU_ADDR_W'(IMG_WORDS - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  sched_state_t          state_q, state_d;
  logic [NPU_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic                  we_q, we_d;
  logic [NPU_ADDR_W-1:0] addr_q, addr_d;
  logic [NPU_DATA_W-1:0] din_q, din_d;
  logic                  start_q, start_d;
  logic                  rv_q, rv_d;
  logic [CLASS_W-1:0]    class_q, class_d;
  logic                  terr_q, terr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  enable_q;
  logic                  drop_inc, short_inc;
  logic [NPU_ADDR_W-1:0] wr_idx;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    start_d   = 1'b0;
    rv_d      = 1'b0;
    class_d   = class_q;
    terr_d    = terr_q;
    tmo_d     = tmo_q;
    drop_inc  = 1'b0;
    short_inc = 1'b0;
    wr_idx    = '0;

    // Re-enabling acknowledges a previous timeout; a timeout in this same
    // cycle still sets the flag below.
    if (enable && !enable_q) begin
      terr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT_SOF;
        end
      end

      S_WAIT_SOF, S_LOAD: begin
        if (!enable) begin
          // Partial frame is abandoned; nothing more is written.
          state_d = S_IDLE;
        end else begin
          if (frame_start) begin
            state_d   = S_LOAD;
            wr_ptr_d  = '0;
            short_inc = (state_q == S_LOAD);
          end
          // A pixel coinciding with frame_start is the first word of the new frame.
          if (pix_valid && (frame_start || (state_q == S_LOAD))) begin
            wr_idx = frame_start ? '0 : wr_ptr_q;
            we_d   = 1'b1;
            addr_d = wr_idx;
            din_d  = pix_data;
            if (wr_idx == LAST_ADDR) begin
              state_d = S_START;
            end else begin
              wr_ptr_d = wr_idx + 1'b1;
            end
          end
        end
      end

      S_START: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        drop_inc = frame_start;
        if (npu_done) begin
          class_d = npu_class;
          rv_d    = 1'b1;
          state_d = enable ? S_WAIT_SOF : S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = enable ? S_WAIT_SOF : S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      start_q  <= 1'b0;
      rv_q     <= 1'b0;
      class_q  <= '0;
      terr_q   <= 1'b0;
      tmo_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      start_q  <= start_d;
      rv_q     <= rv_d;
      class_q  <= class_d;
      terr_q   <= terr_d;
      tmo_q    <= tmo_d;
      enable_q <= enable;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .inc_i   (drop_inc),
    .clear_i (1'b0),
    .cnt_o   (drop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_short_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .inc_i   (short_inc),
    .clear_i (1'b0),
    .cnt_o   (short_cnt)
  );

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_din      = din_q;
  assign npu_start    = start_q;
  assign result_valid = rv_q;
  assign result_class = class_q;
  assign timeout_err  = terr_q;
  assign busy         = (state_q == S_START) || (state_q == S_RUN);

endmodule

// File: tb/tb_npu_frame_scheduler.sv
// Purpose : self-checking bench for npu_frame_scheduler against a frame-level reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_npu_frame_scheduler;

  localparam int IMG     = 3072;
  localparam int CLS_W   = 5;
  localparam int TMO     = 100;
  localparam int CW      = 3;            // small counters so saturation is reachable
  localparam int CMAX    = (1 << CW) - 1;

  // Reference model phases (frame-level view of the scheduler).
  localparam int P_OFF = 0, P_ARMED = 1, P_FILL = 2, P_KICK = 3, P_INFER = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             enable = 1'b0;
  logic             frame_start = 1'b0;
  logic             pix_valid = 1'b0;
  logic [7:0]       pix_data = '0;
  logic             npu_done = 1'b0;
  logic [CLS_W-1:0] npu_class = '0;
  logic             mem_we, npu_start, result_valid, timeout_err, busy;
  logic [11:0]      mem_addr;
  logic [7:0]       mem_din;
  logic [CLS_W-1:0] result_class;
  logic [CW-1:0]    drop_cnt, short_cnt;

  npu_frame_scheduler #(
    .IMG_WORDS(IMG), .CLASS_W(CLS_W), .TIMEOUT_CYC(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .npu_start(npu_start), .npu_done(npu_done), .npu_class(npu_class),
    .result_valid(result_valid), .result_class(result_class), .timeout_err(timeout_err),
    .drop_cnt(drop_cnt), .short_cnt(short_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_st = 0;

  // model state and expected outputs
  int m_phase, m_words, m_run;
  bit m_en_prev;
  int e_we, e_addr, e_din, e_start, e_rv, e_class, e_terr, e_drop, e_short;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_inc(int v);
    return (v >= CMAX) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_phase = P_OFF; m_words = 0; m_run = 0; m_en_prev = 0;
    e_we = 0; e_addr = 0; e_din = 0; e_start = 0; e_rv = 0;
    e_class = 0; e_terr = 0; e_drop = 0; e_short = 0;
  endtask

  // Accept one pixel into the frame being assembled.
  task automatic model_store();
    e_we = 1; e_addr = m_words; e_din = int'(pix_data);
    m_words++;
    if (m_words == IMG) m_phase = P_KICK;
  endtask

  // Advance the model over one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (!resetn) begin
      model_reset();
      return;
    end
    e_we = 0; e_start = 0; e_rv = 0;
    if (enable && !m_en_prev) e_terr = 0;
    m_en_prev = enable;
    case (m_phase)
      P_OFF: if (enable) m_phase = P_ARMED;
      P_ARMED, P_FILL: begin
        if (!enable) m_phase = P_OFF;
        else if (frame_start) begin
          if (m_phase == P_FILL) e_short = sat_inc(e_short);
          m_phase = P_FILL; m_words = 0;
          if (pix_valid) model_store();
        end else if (m_phase == P_FILL && pix_valid) model_store();
      end
      P_KICK: begin
        e_start = 1; m_phase = P_INFER; m_run = 0;
      end
      P_INFER: begin
        if (frame_start) e_drop = sat_inc(e_drop);
        if (npu_done) begin
          e_class = int'(npu_class); e_rv = 1;
          m_phase = enable ? P_ARMED : P_OFF;
        end else begin
          m_run++;
          if (m_run == TMO) begin
            e_terr = 1;
            m_phase = enable ? P_ARMED : P_OFF;
          end
        end
      end
      default: m_phase = P_OFF;
    endcase
  endtask

  task automatic compare_all();
    chk_eq("mem_we", mem_we, e_we);
    chk_eq("mem_addr", mem_addr, e_addr);
    chk_eq("mem_din", mem_din, e_din);
    chk_eq("npu_start", npu_start, e_start);
    chk_eq("result_valid", result_valid, e_rv);
    chk_eq("result_class", result_class, e_class);
    chk_eq("timeout_err", timeout_err, e_terr);
    chk_eq("drop_cnt", drop_cnt, e_drop);
    chk_eq("short_cnt", short_cnt, e_short);
    chk_eq("busy", busy, (m_phase == P_KICK || m_phase == P_INFER) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (mem_we) n_wr++;
    if (npu_start) n_st++;
  endtask

  task automatic quiet();
    frame_start = 0; pix_valid = 0; npu_done = 0;
  endtask

  // Feed n consecutive pixels, optionally with frame_start on the first.
  task automatic feed(input int n, input bit sof);
    for (int i = 0; i < n; i++) begin
      frame_start = sof && (i == 0);
      pix_valid = 1;
      pix_data = 8'(i);
      tick();
    end
    quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // reset state
    tick(); tick();
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_we", mem_we, 0);
    resetn = 1;
    enable = 1;
    tick(); tick();

    // 1: full ramp frame
    n_wr = 0; n_st = 0;
    feed(IMG, 1);
    chk_eq("t1_writes", n_wr, IMG);
    chk_eq("t1_last_addr", mem_addr, IMG - 1);
    chk_eq("t1_no_start_yet", n_st, 0);
    tick();
    chk_eq("t1_start", npu_start, 1);
    tick();
    chk_eq("t1_start_once", n_st, 1);
    chk_eq("t1_busy", busy, 1);

    // 2: completion with class 17
    tick();
    npu_done = 1; npu_class = 5'd17;
    tick();
    quiet();
    chk_eq("t2_rv", result_valid, 1);
    chk_eq("t2_class", result_class, 17);
    chk_eq("t2_busy", busy, 0);
    tick();
    chk_eq("t2_rv_pulse", result_valid, 0);

    // 3: short frame restart
    feed(1000, 1);
    frame_start = 1; pix_valid = 1; pix_data = 8'hA5;
    tick();
    quiet();
    chk_eq("t3_short", short_cnt, 1);
    chk_eq("t3_addr0", mem_addr, 0);
    chk_eq("t3_we", mem_we, 1);
    n_st = 0;
    feed(IMG - 1, 0);
    chk_eq("t3_no_early_start", n_st, 0);
    tick();
    chk_eq("t3_start", n_st, 1);

    // 4: two dropped frames during RUN, then a normal frame
    n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      frame_start = (k == 1 || k == 3);
      pix_valid = 1;
      tick();
    end
    quiet();
    chk_eq("t4_drop", drop_cnt, 2);
    chk_eq("t4_no_writes", n_wr, 0);
    npu_done = 1; npu_class = 5'd3;
    tick();
    quiet();
    n_wr = 0; n_st = 0;
    feed(IMG, 1);
    tick();
    chk_eq("t4_reload_writes", n_wr, IMG);
    chk_eq("t4_reload_start", n_st, 1);

    // 5: timeout, with drop counter pushed into saturation meanwhile
    for (int k = 1; k <= TMO; k++) begin
      frame_start = (k <= 16) && (k % 2 == 1);
      tick();
      if (k == TMO - 1) chk_eq("t5_terr_early", timeout_err, 0);
    end
    quiet();
    chk_eq("t5_terr", timeout_err, 1);
    chk_eq("t5_drop_sat", drop_cnt, CMAX);
    chk_eq("t5_busy", busy, 0);

    // 6a: enable low mid-LOAD discards the frame
    feed(500, 1);
    enable = 0;
    n_wr = 0;
    for (int k = 0; k < 5; k++) begin
      pix_valid = 1; tick();
    end
    quiet();
    chk_eq("t6_no_writes", n_wr, 0);
    chk_eq("t6_busy", busy, 0);
    enable = 1;
    tick();
    chk_eq("t6_terr_clear", timeout_err, 0);
    tick();

    // 6b: reset asserted during RUN
    feed(IMG, 1);
    tick(); tick(); tick();
    resetn = 0;
    model_reset();
    #1;
    chk_eq("t6_rst_busy", busy, 0);
    chk_eq("t6_rst_drop", drop_cnt, 0);
    chk_eq("t6_rst_short", short_cnt, 0);
    chk_eq("t6_rst_class", result_class, 0);
    n_st = 0;
    tick(); tick();
    chk_eq("t6_rst_no_start", n_st, 0);
    resetn = 1;
    tick();

    // randomized traffic
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      frame_start = ($urandom_range(0, 3999) == 0);
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_data = 8'($urandom);
      npu_done = ($urandom_range(0, 59) == 0);
      npu_class = CLS_W'($urandom);
      tick();
    end
    quiet();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
